// File: rtl/wb_lane_stream_mem.sv
// wb_lane_stream_mem: NUM_LANES independent DEPTH x DATA_W weight/bias banks.
// Banks are loaded one word at a time from the CPU side. A start command streams a
// contiguous address range, all lanes per beat, over a valid/ready handshake.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   wr_en/lane/addr/data  single-lane bank write (accepted only while idle)
//   start, base_addr, len launch a stream of len beats from base_addr (wraps)
//   busy, done            stream in progress / one-cycle end-of-stream pulse
//   out_valid/ready/last  output beat handshake and final-beat marker
//   out_data              lane k at [k*DATA_W +: DATA_W]
//   err                   sticky protocol error (bad write or start while busy)
module wb_lane_stream_mem #(
   parameter  int NUM_LANES = 32,
   parameter  int DATA_W    = 32,
   parameter  int DEPTH     = 1024,
   localparam int ADDR_W    = $clog2(DEPTH),
   localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        wr_en,
   input  logic [LANE_W-1:0]           wr_lane,
   input  logic [ADDR_W-1:0]           wr_addr,
   input  logic [DATA_W-1:0]           wr_data,
   input  logic                        start,
   input  logic [ADDR_W-1:0]           base_addr,
   input  logic [ADDR_W:0]             len,
   output logic                        busy,
   output logic                        done,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        out_last,
   output logic [NUM_LANES*DATA_W-1:0] out_data,
   output logic                        err
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam logic [LANE_W:0] LANE_CNT = (LANE_W+1)'(NUM_LANES);

   logic [0:0]                  state_q, state_d;
   logic [ADDR_W-1:0]           raddr_q, raddr_d;
   logic [ADDR_W:0]             rem_q, rem_d;
   logic                        done_q, done_d;
   logic                        err_q, err_d;
   logic                        rd_vld_q;
   logic                        rd_last_q;
   logic [NUM_LANES*DATA_W-1:0] rd_data;

   logic [NUM_LANES*DATA_W-1:0] fdat_q [2];
   logic [1:0]                  flast_q;
   logic                        wptr_q;
   logic                        rptr_q;
   logic [1:0]                  cnt_q, cnt_d;

   logic       idle;
   logic       lane_ok;
   logic       wr_ok;
   logic       push;
   logic       pop;
   logic       last_xfer;
   logic [2:0] occ;
   logic       room;
   logic       issue;

   assign idle    = (state_q == S_IDLE);
   assign lane_ok = ({1'b0, wr_lane} < LANE_CNT);
   assign wr_ok   = wr_en && idle && lane_ok;

   assign out_valid = (cnt_q != 2'd0);
   assign out_data  = fdat_q[rptr_q];
   // A drained head entry may still carry a stale last flag.
   assign out_last  = out_valid && flast_q[rptr_q];
   assign busy      = (state_q == S_RUN);
   assign done      = done_q;
   assign err       = err_q;

   assign push      = rd_vld_q;
   assign pop       = out_valid && out_ready;
   assign last_xfer = pop && out_last;

   // Beats in flight (RAM stage + skid) must never exceed the two skid
   // slots; a pop in this cycle frees one slot for the new read.
   assign occ   = {1'b0, cnt_q} + {2'b00, rd_vld_q};
   assign room  = (occ < 3'd2) || ((occ == 3'd2) && pop);
   assign issue = (state_q == S_RUN) && (rem_q != '0) && room;

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_bank
      logic [DATA_W-1:0] mem_q [DEPTH];
      logic [DATA_W-1:0] rdat_q;

      always_ff @(posedge clk) begin
         if (wr_ok && (wr_lane == LANE_W'(k))) begin
            mem_q[wr_addr] <= wr_data;
         end
         if (issue) begin
            rdat_q <= mem_q[raddr_q];
         end
      end

      assign rd_data[k*DATA_W +: DATA_W] = rdat_q;
   end

   always_comb begin
      state_d = state_q;
      raddr_d = raddr_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = S_RUN;
                  raddr_d = base_addr;
                  rem_d   = len;
               end
            end
         end
         S_RUN: begin
            if (start) begin
               err_d = 1'b1;
            end
            if (issue) begin
               raddr_d = raddr_q + 1'b1;
               rem_d   = rem_q - 1'b1;
            end
            if (last_xfer) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (wr_en && !wr_ok) begin
         err_d = 1'b1;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         raddr_q   <= '0;
         rem_q     <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         rd_vld_q  <= 1'b0;
         rd_last_q <= 1'b0;
         wptr_q    <= 1'b0;
         rptr_q    <= 1'b0;
         cnt_q     <= 2'd0;
         flast_q   <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            fdat_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         raddr_q   <= raddr_d;
         rem_q     <= rem_d;
         done_q    <= done_d;
         err_q     <= err_d;
         rd_vld_q  <= issue;
         rd_last_q <= issue && (rem_q == (ADDR_W+1)'(1));
         cnt_q     <= cnt_d;
         if (push) begin
            fdat_q[wptr_q]  <= rd_data;
            flast_q[wptr_q] <= rd_last_q;
            wptr_q          <= ~wptr_q;
         end
         if (pop) begin
            rptr_q <= ~rptr_q;
         end
      end
   end

endmodule

// File: tb/tb_wb_lane_stream_mem.sv
// tb_wb_lane_stream_mem: directed bench for the multi-lane stream store.
// Word pattern for lane j, address a is {j[15:0], a[15:0]}.
module tb_wb_lane_stream_mem;

   localparam int NL = 32;
   localparam int DW = 32;

   logic           clk;
   logic           reset;
   logic           wr_en;
   logic [4:0]     wr_lane;
   logic [9:0]     wr_addr;
   logic [31:0]    wr_data;
   logic           start;
   logic [9:0]     base_addr;
   logic [10:0]    len_r;
   logic           busy;
   logic           done;
   logic           out_valid;
   logic           out_ready;
   logic           out_last;
   logic [NL*DW-1:0] out_data;
   logic           err;

   logic           n_wr_en;
   logic [3:0]     n_wr_lane;
   logic [9:0]     n_wr_addr;
   logic [31:0]    n_wr_data;
   logic           n_start;
   logic [9:0]     n_base;
   logic [10:0]    n_len;
   logic           n_busy;
   logic           n_done;
   logic           n_valid;
   logic           n_ready;
   logic           n_last;
   logic [10*DW-1:0] n_data;
   logic           n_err;

   int errs;
   int checks;

   wb_lane_stream_mem u_dut (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (wr_en),
      .wr_lane   (wr_lane),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .start     (start),
      .base_addr (base_addr),
      .len       (len_r),
      .busy      (busy),
      .done      (done),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .out_data  (out_data),
      .err       (err)
   );

   wb_lane_stream_mem #(.NUM_LANES(10)) u_nl (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (n_wr_en),
      .wr_lane   (n_wr_lane),
      .wr_addr   (n_wr_addr),
      .wr_data   (n_wr_data),
      .start     (n_start),
      .base_addr (n_base),
      .len       (n_len),
      .busy      (n_busy),
      .done      (n_done),
      .out_valid (n_valid),
      .out_ready (n_ready),
      .out_last  (n_last),
      .out_data  (n_data),
      .err       (n_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_w(input int j, input int a);
      return {j[15:0], a[15:0]};
   endfunction

   function automatic logic rdy(input int mode, input int c);
      logic [6:0] seq;
      int idx;
      seq = 7'b0000101;
      idx = c - 2;
      if (mode == 0) return 1'b1;
      if (idx < 0) return 1'b0;
      if (idx > 6) return 1'b1;
      return seq[idx];
   endfunction

   task automatic wr(input int j, input int a, input logic [31:0] d);
      wr_en   = 1'b1;
      wr_lane = j[4:0];
      wr_addr = a[9:0];
      wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   // ev: 0 none, 1 start while busy, 2 write while busy,
   //     3 write in start cycle, 4 reset during beat 2
   task automatic stream(input int tid, input int base, input int len,
                         input int rmode, input int ev);
      int c;
      int n;
      int first;
      logic prev_stall;
      logic [NL*DW-1:0] prev;
      logic prev_last;
      start     = 1'b1;
      base_addr = base[9:0];
      len_r     = len[10:0];
      if (ev == 3) begin
         wr_en   = 1'b1;
         wr_lane = 5'd5;
         wr_addr = 10'd1022;
         wr_data = exp_w(5, 1022);
      end
      tick();
      start      = 1'b0;
      wr_en      = 1'b0;
      n          = 0;
      c          = 0;
      first      = -1;
      prev_stall = 1'b0;
      prev       = '0;
      prev_last  = 1'b0;
      check($sformatf("t%0d_busy0", tid), busy, 1);
      while (n < len && c < 60) begin
         if (ev == 4 && c == 4) begin
            reset     = 1'b1;
            out_ready = 1'b0;
            tick();
            reset = 1'b0;
            check("rst_busy", busy, 0);
            check("rst_valid", out_valid, 0);
            check("rst_done", done, 0);
            check("rst_err", err, 0);
            check("rst_last", out_last, 0);
            check("rst_data0", out_data == '0, 1);
            tick();
            check("rst_idle", busy | out_valid | done, 0);
            return;
         end
         if (ev == 1 && c == 1) begin
            start     = 1'b1;
            base_addr = 10'd500;
            len_r     = 11'd7;
         end else begin
            start = 1'b0;
         end
         if (ev == 2 && c == 1) begin
            wr_en   = 1'b1;
            wr_lane = 5'd2;
            wr_addr = 10'd1;
            wr_data = 32'hDEADBEEF;
         end else begin
            wr_en = 1'b0;
         end
         out_ready = rdy(rmode, c);
         if (prev_stall) begin
            check($sformatf("t%0d_hold_c%0d", tid, c), out_data == prev, 1);
            check($sformatf("t%0d_holdl_c%0d", tid, c), out_last, prev_last);
         end
         if (out_valid) begin
            if (first < 0) first = c;
            check($sformatf("t%0d_last_b%0d", tid, n), out_last, n == len - 1);
            if (out_ready) begin
               for (int j = 0; j < NL; j++) begin
                  check($sformatf("t%0d_b%0d_l%0d", tid, n, j),
                        out_data[j*DW +: DW], exp_w(j, (base + n) % 1024));
               end
               n++;
            end
         end
         prev_stall = out_valid && !out_ready;
         prev       = out_data;
         prev_last  = out_last;
         tick();
         c++;
      end
      start     = 1'b0;
      wr_en     = 1'b0;
      out_ready = 1'b0;
      check($sformatf("t%0d_beats", tid), n, len);
      check($sformatf("t%0d_lat", tid), first, 2);
      if (rmode == 0) check($sformatf("t%0d_endc", tid), c, len + 2);
      check($sformatf("t%0d_done", tid), done, 1);
      check($sformatf("t%0d_busy_end", tid), busy, 0);
      check($sformatf("t%0d_valid_end", tid), out_valid, 0);
      tick();
      check($sformatf("t%0d_done_off", tid), done, 0);
      check($sformatf("t%0d_valid_off", tid), out_valid, 0);
   endtask

   initial begin
      int c;
      errs      = 0;
      checks    = 0;
      reset     = 1'b1;
      wr_en     = 1'b0;
      wr_lane   = '0;
      wr_addr   = '0;
      wr_data   = '0;
      start     = 1'b0;
      base_addr = '0;
      len_r     = '0;
      out_ready = 1'b0;
      n_wr_en   = 1'b0;
      n_wr_lane = '0;
      n_wr_addr = '0;
      n_wr_data = '0;
      n_start   = 1'b0;
      n_base    = '0;
      n_len     = '0;
      n_ready   = 1'b0;
      tick();
      tick();
      check("rst0_busy", busy, 0);
      check("rst0_done", done, 0);
      check("rst0_valid", out_valid, 0);
      check("rst0_last", out_last, 0);
      check("rst0_err", err, 0);
      check("rst0_data", out_data == '0, 1);
      reset = 1'b0;
      tick();

      for (int j = 0; j < NL; j++) begin
         for (int a = 0; a < 4; a++) wr(j, a, exp_w(j, a));
         if (j != 5) wr(j, 1022, exp_w(j, 1022));
         wr(j, 1023, exp_w(j, 1023));
      end
      check("wr_err0", err, 0);

      stream(1, 0, 4, 0, 0);
      stream(2, 0, 4, 1, 0);
      stream(3, 1022, 4, 0, 3);
      check("t3_err", err, 0);

      start = 1'b1;
      len_r = 11'd0;
      tick();
      start = 1'b0;
      check("t4_z_done", done, 1);
      check("t4_z_busy", busy, 0);
      check("t4_z_valid", out_valid, 0);
      tick();
      check("t4_z_done_off", done, 0);
      check("t4_z_valid1", out_valid, 0);
      tick();
      check("t4_z_valid2", out_valid | busy, 0);
      check("t4_z_err", err, 0);
      stream(4, 0, 4, 0, 1);
      check("t4_err", err, 1);

      stream(5, 0, 4, 0, 4);
      stream(6, 0, 4, 0, 0);
      check("t6_err0", err, 0);

      stream(7, 0, 4, 0, 2);
      check("t7_err", err, 1);
      stream(8, 0, 4, 0, 0);

      for (int j = 0; j < 10; j++) begin
         n_wr_en   = 1'b1;
         n_wr_lane = j[3:0];
         n_wr_addr = 10'd0;
         n_wr_data = exp_w(j, 0);
         tick();
      end
      n_wr_en = 1'b0;
      check("nl_err0", n_err, 0);
      n_wr_en   = 1'b1;
      n_wr_lane = 4'd12;
      n_wr_data = 32'hDEADBEEF;
      tick();
      n_wr_en = 1'b0;
      check("nl_err", n_err, 1);
      n_start = 1'b1;
      n_base  = 10'd0;
      n_len   = 11'd1;
      n_ready = 1'b1;
      tick();
      n_start = 1'b0;
      c = 0;
      while (!n_valid && c < 10) begin
         tick();
         c++;
      end
      check("nl_valid", n_valid, 1);
      check("nl_last", n_last, 1);
      for (int j = 0; j < 10; j++) begin
         check($sformatf("nl_l%0d", j), n_data[j*DW +: DW], exp_w(j, 0));
      end
      tick();
      check("nl_done", n_done, 1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
